mult_div_unit: RTL and testbench
================================

# mult_div_unit

Iterative multiply/divide unit for the MIPS datapath, owning the HI and LO registers. It executes MULT, MULTU, DIV and DIVU over several cycles and holds the 64-bit result in HI/LO. MTHI and MTLO write those registers directly. The `hi` and `lo` outputs feed the writeback-select mux alongside the ALU result. `busy` drives the hazard logic so that MFHI/MFLO stall until the result is valid.

## Interface
- `WIDTH`, default 32: operand width and width of each of HI and LO.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: launch an operation; sampled only when `busy`=0.
- `op` in 2: operation select. 00 = MULT (signed), 01 = MULTU, 10 = DIV (signed), 11 = DIVU.
- `a` in WIDTH: rs operand (multiplicand or dividend); captured when `start` is accepted.
- `b` in WIDTH: rt operand (multiplier or divisor); captured when `start` is accepted.
- `hi_we` in 1: MTHI write enable.
- `lo_we` in 1: MTLO write enable.
- `wdata` in WIDTH: MTHI/MTLO write data.
- `busy` out 1: operation in progress.
- `done` out 1: one-cycle pulse; HI/LO hold the new result.
- `hi` out WIDTH: HI register.
- `lo` out WIDTH: LO register.

## Operation
- States:
  - IDLE: `busy`=0.
  - RUN: `busy`=1; WIDTH iterations.
  - FIX: `busy`=1; sign fix-up and result commit.
- IDLE -> RUN on `start`: capture `op`, `|a|` and `|b|` (absolute values for signed ops; raw values for unsigned ops), and the result sign flags. Clear the iteration counter.
- RUN, multiply: shift-add, one multiplier bit per cycle, into a 2*WIDTH accumulator.
- RUN, divide: restoring division, one quotient bit per cycle, producing a WIDTH-bit remainder.
- RUN -> FIX when the counter reaches WIDTH-1.
- FIX -> IDLE unconditionally. On this edge: `hi`/`lo` are written and `done` goes to 1 for one cycle.
- Multiply result: `hi` = product[2W-1:W], `lo` = product[W-1:0]. Signed ops negate the 2W-bit product when sign(a) XOR sign(b).
- Divide result: `lo` = quotient, `hi` = remainder.
  - Signed quotient is negated when the operand signs differ.
  - Signed remainder takes the sign of the dividend.
  - All results are truncated to WIDTH bits.
- Divide by zero (`b`=0), both DIV and DIVU: `lo` = all ones, `hi` = `a`. The full latency still applies.
- Signed overflow (a = 0x80000000, b = 0xFFFFFFFF): `lo` = 0x80000000, `hi` = 0. This falls out of the wrap, with no special case.
- `start` while `busy`=1 is ignored; captured operands are not disturbed.
- `hi_we`/`lo_we`:
  - In IDLE with `start`=0: write `wdata` at the next edge. Both may be set in the same cycle.
  - While `busy`=1: ignored.
  - Same cycle as an accepted `start`: ignored; `start` wins.
- `hi`/`lo` hold their value in all other cycles. A new operation does not change them until FIX.

## Timing
- Reset, when `rst`=1 at an edge:
  - State goes to IDLE.
  - `busy`=0, `done`=0, `hi`=0, `lo`=0.
  - The counter and accumulators are cleared.
  - This applies mid-operation too: the in-flight result is discarded and `done` never pulses.
- Cycle numbering: `start` is accepted at edge E0.
  - `busy`=1 after E0 through E(WIDTH).
  - At edge E(WIDTH+1): `busy`=0, `done`=1, and the new `hi`/`lo` become valid together.
  - Total: WIDTH+1 cycles from acceptance to result (33 for WIDTH=32).
- Back-to-back: `start` asserted during the `done` cycle is accepted (`busy`=0). `busy` returns to 1 after that edge.
- `busy`, `done`, `hi` and `lo` are all registered outputs, with no combinational path from the inputs.
- Same-cycle ordering: `hi_we`/`lo_we` writes are visible on the next cycle only.

## Test plan
- MULT a=0xFFFFFFFD (-3), b=7 -> after 33 cycles: `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB, `done` pulses exactly once, `busy` high for 33 cycles.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> `hi`=0xFFFFFFFE, `lo`=0x00000001. DIVU a=100, b=7 -> `lo`=14, `hi`=2.
- DIV a=-7 (0xFFFFFFF9), b=2 -> `lo`=0xFFFFFFFD (-3), `hi`=0xFFFFFFFF (-1). Then DIV a=0x80000000, b=0xFFFFFFFF -> `lo`=0x80000000, `hi`=0.
- DIVU a=0x12345678, b=0 -> `lo`=0xFFFFFFFF, `hi`=0x12345678, at normal latency.
- During MULT: assert `start` with new operands and `hi_we`=1, `wdata`=0xDEADBEEF, while `busy`=1 -> both ignored; the original product is committed. In IDLE: `lo_we`=1, `wdata`=0x55 -> `lo`=0x55 next cycle and `hi` unchanged.
- Reset: assert `rst` for 1 cycle at cycle 10 of a DIV -> `busy`=0, `hi`=`lo`=0 next cycle, no `done` pulse. A fresh MULTU 3*5 then yields `lo`=15 with `start` in the `done` cycle accepted back-to-back.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit owning HI/LO: shift-add multiply and
// restoring divide, one bit per cycle, with a sign fix-up/commit cycle at the end.
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } state_e;

   function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v,
                                                input logic             is_signed);
      abs_val = (is_signed && v[WIDTH-1]) ? (-v) : v;
   endfunction

   state_e             state_q;
   logic [CW-1:0]      cnt_q;
   logic               is_div_q;
   logic               neg_q;
   logic               neg_rem_q;
   logic               dz_q;
   logic [WIDTH-1:0]   opnd_q;
   logic [2*WIDTH-1:0] acc_q;
   logic               busy_q;
   logic               done_q;
   logic [WIDTH-1:0]   hi_q;
   logic [WIDTH-1:0]   lo_q;

   logic               op_signed_s;
   logic [WIDTH-1:0]   a_abs_s;
   logic [WIDTH-1:0]   b_abs_s;
   logic [WIDTH:0]     mul_sum_s;
   logic [WIDTH:0]     div_shift_s;
   logic [WIDTH-1:0]   div_diff_s;
   logic               div_ge_s;
   logic [WIDTH-1:0]   div_rem_s;
   logic [2*WIDTH-1:0] acc_d;
   logic [2*WIDTH-1:0] mul_prod_s;
   logic [WIDTH-1:0]   quo_s;
   logic [WIDTH-1:0]   rem_s;
   logic [WIDTH-1:0]   res_hi_s;
   logic [WIDTH-1:0]   res_lo_s;

   // Operand conditioning for a starting operation: MULT/DIV run on magnitudes.
   always_comb begin
      op_signed_s = ~op[0];
      a_abs_s     = abs_val(a, op_signed_s);
      b_abs_s     = abs_val(b, op_signed_s);
   end

   // One iteration step. Multiply keeps {partial product, remaining multiplier};
   // divide keeps {remainder, dividend bits shifting into quotient bits}.
   always_comb begin
      mul_sum_s   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                  + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
      div_shift_s = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      div_ge_s    = (div_shift_s >= {1'b0, opnd_q});
      div_diff_s  = div_shift_s[WIDTH-1:0] - opnd_q;
      div_rem_s   = div_ge_s ? div_diff_s : div_shift_s[WIDTH-1:0];
      if (is_div_q) begin
         acc_d = {div_rem_s, acc_q[WIDTH-2:0], div_ge_s};
      end else begin
         acc_d = {mul_sum_s, acc_q[WIDTH-1:1]};
      end
   end

   // Sign fix-up of the finished magnitude result; zero divisor forces all-ones quotient.
   always_comb begin
      mul_prod_s = neg_q ? (-acc_q) : acc_q;
      quo_s      = acc_q[WIDTH-1:0];
      rem_s      = acc_q[2*WIDTH-1:WIDTH];
      if (is_div_q) begin
         res_lo_s = dz_q ? {WIDTH{1'b1}} : (neg_q ? (-quo_s) : quo_s);
         res_hi_s = neg_rem_q ? (-rem_s) : rem_s;
      end else begin
         res_lo_s = mul_prod_s[WIDTH-1:0];
         res_hi_s = mul_prod_s[2*WIDTH-1:WIDTH];
      end
   end

   // Control FSM, datapath registers and HI/LO; all outputs come straight from here.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= {CW{1'b0}};
         is_div_q  <= 1'b0;
         neg_q     <= 1'b0;
         neg_rem_q <= 1'b0;
         dz_q      <= 1'b0;
         opnd_q    <= {WIDTH{1'b0}};
         acc_q     <= {(2*WIDTH){1'b0}};
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         hi_q      <= {WIDTH{1'b0}};
         lo_q      <= {WIDTH{1'b0}};
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  state_q   <= RUN;
                  busy_q    <= 1'b1;
                  cnt_q     <= {CW{1'b0}};
                  is_div_q  <= op[1];
                  neg_q     <= op_signed_s & (a[WIDTH-1] ^ b[WIDTH-1]);
                  neg_rem_q <= op_signed_s & a[WIDTH-1];
                  dz_q      <= (b == {WIDTH{1'b0}});
                  if (op[1]) begin
                     opnd_q <= b_abs_s;
                     acc_q  <= {{WIDTH{1'b0}}, a_abs_s};
                  end else begin
                     opnd_q <= a_abs_s;
                     acc_q  <= {{WIDTH{1'b0}}, b_abs_s};
                  end
               end else begin
                  if (hi_we) begin
                     hi_q <= wdata;
                  end
                  if (lo_we) begin
                     lo_q <= wdata;
                  end
               end
            end
            RUN: begin
               done_q <= 1'b0;
               acc_q  <= acc_d;
               cnt_q  <= cnt_q + CW'(1);
               if (cnt_q == CNT_LAST) begin
                  state_q <= FIX;
               end
            end
            FIX: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               hi_q    <= res_hi_s;
               lo_q    <= res_lo_s;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit (WIDTH=32): results, latency,
// busy-time interference, MTHI/MTLO, mid-operation reset and back-to-back start.
module tb_mult_div_unit;

   logic        clk;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        hi_we;
   logic        lo_we;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_cmp = 0;
   int n_err = 0;
   int cyc;
   int dcnt;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   mult_div_unit #(.WIDTH(32)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .hi_we (hi_we),
      .lo_we (lo_we),
      .wdata (wdata),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge with busy=0; returns at the first sample after acceptance.
   task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Counts busy samples until done is seen (bounded); returns sitting in the done cycle.
   task automatic wait_done(output int busy_cycles);
      busy_cycles = 0;
      for (int i = 0; i < 100; i++) begin
         if (done === 1'b1) break;
         if (busy === 1'b1) busy_cycles++;
         @(negedge clk);
      end
      check("done_seen", 64'(done), 64'd1);
      check("busy_clear_at_done", 64'(busy), 64'd0);
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      op    = 2'b00;
      a     = 32'd0;
      b     = 32'd0;
      hi_we = 1'b0;
      lo_we = 1'b0;
      wdata = 32'd0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_hi", 64'(hi), 64'd0);
      check("rst_lo", 64'(lo), 64'd0);

      // MULT -3 * 7
      launch(OP_MULT, 32'hFFFF_FFFD, 32'd7);
      check("mult_busy_early", 64'(busy), 64'd1);
      check("mult_hi_held", 64'(hi), 64'd0);
      wait_done(cyc);
      check("mult_latency", 64'(cyc), 64'd33);
      check("mult_hi", 64'(hi), 64'hFFFF_FFFF);
      check("mult_lo", 64'(lo), 64'hFFFF_FFEB);
      @(negedge clk);
      check("mult_done_pulse", 64'(done), 64'd0);

      launch(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done(cyc);
      check("multu_hi", 64'(hi), 64'hFFFF_FFFE);
      check("multu_lo", 64'(lo), 64'h0000_0001);
      @(negedge clk);

      launch(OP_DIVU, 32'd100, 32'd7);
      wait_done(cyc);
      check("divu_lo", 64'(lo), 64'd14);
      check("divu_hi", 64'(hi), 64'd2);
      @(negedge clk);

      launch(OP_DIV, 32'hFFFF_FFF9, 32'd2);
      wait_done(cyc);
      check("div_neg_lo", 64'(lo), 64'hFFFF_FFFD);
      check("div_neg_hi", 64'(hi), 64'hFFFF_FFFF);
      @(negedge clk);

      launch(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done(cyc);
      check("div_ovf_lo", 64'(lo), 64'h8000_0000);
      check("div_ovf_hi", 64'(hi), 64'h0000_0000);
      @(negedge clk);

      launch(OP_DIVU, 32'h1234_5678, 32'd0);
      wait_done(cyc);
      check("div0_latency", 64'(cyc), 64'd33);
      check("div0_lo", 64'(lo), 64'hFFFF_FFFF);
      check("div0_hi", 64'(hi), 64'h1234_5678);
      @(negedge clk);

      // MULT 6 * -5 with a start and MTHI attempted while busy
      launch(OP_MULT, 32'd6, 32'hFFFF_FFFB);
      repeat (5) @(negedge clk);
      start = 1'b1;
      op    = OP_DIVU;
      a     = 32'd1;
      b     = 32'd1;
      hi_we = 1'b1;
      wdata = 32'hDEAD_BEEF;
      @(negedge clk);
      start = 1'b0;
      hi_we = 1'b0;
      check("busy_mthi_ignored", 64'(hi), 64'h1234_5678);
      wait_done(cyc);
      check("interf_latency", 64'(6 + cyc), 64'd33);
      check("interf_hi", 64'(hi), 64'hFFFF_FFFF);
      check("interf_lo", 64'(lo), 64'hFFFF_FFE2);
      @(negedge clk);

      lo_we = 1'b1;
      wdata = 32'h55;
      @(negedge clk);
      lo_we = 1'b0;
      check("mtlo_lo", 64'(lo), 64'h55);
      check("mtlo_hi_kept", 64'(hi), 64'hFFFF_FFFF);
      hi_we = 1'b1;
      lo_we = 1'b1;
      wdata = 32'hA5;
      @(negedge clk);
      hi_we = 1'b0;
      lo_we = 1'b0;
      check("mthilo_hi", 64'(hi), 64'hA5);
      check("mthilo_lo", 64'(lo), 64'hA5);

      // Reset at cycle 10 of a DIV
      launch(OP_DIV, 32'd100, 32'd7);
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_hi", 64'(hi), 64'd0);
      check("midrst_lo", 64'(lo), 64'd0);
      dcnt = 0;
      for (int i = 0; i < 40; i++) begin
         if (done === 1'b1) dcnt++;
         @(negedge clk);
      end
      check("midrst_no_done", 64'(dcnt), 64'd0);
      check("midrst_lo_hold", 64'(lo), 64'd0);

      launch(OP_MULTU, 32'd3, 32'd5);
      wait_done(cyc);
      check("m35_lo", 64'(lo), 64'd15);
      check("m35_hi", 64'(hi), 64'd0);
      launch(OP_MULTU, 32'd4, 32'd6);
      check("b2b_busy", 64'(busy), 64'd1);
      check("b2b_done_low", 64'(done), 64'd0);
      wait_done(cyc);
      check("b2b_latency", 64'(cyc), 64'd33);
      check("b2b_lo", 64'(lo), 64'd24);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
